// File: rtl/demokit_vga_timing.sv
// rtl/demokit_vga_timing.sv - parametrised VGA raster timing generator (h/v counters, syncs, de, x/y, pulses, frame count)
// Optional DEMOKIT_VGA_PIPE_EN adds one register stage on every output (latency 2 instead of 1).
module demokit_vga_timing #(
   parameter int H_ACTIVE  = 640,
   parameter int H_FP      = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BP      = 48,
   parameter int V_ACTIVE  = 480,
   parameter int V_FP      = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BP      = 33,
   parameter int HSYNC_POL = 0,
   parameter int VSYNC_POL = 0,
   parameter int FRAME_W   = 8,
   localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
   localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
   localparam int XW       = $clog2(H_TOTAL),
   localparam int YW       = $clog2(V_TOTAL)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   output logic               hsync,
   output logic               vsync,
   output logic               de,
   output logic [XW-1:0]      x,
   output logic [YW-1:0]      y,
   output logic               line_start,
   output logic               frame_start,
   output logic [FRAME_W-1:0] frame
);

   localparam logic [XW-1:0] H_ACT_C  = XW'(H_ACTIVE);
   localparam logic [XW-1:0] H_SS_C   = XW'(H_ACTIVE + H_FP);
   localparam logic [XW-1:0] H_SE_C   = XW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [XW-1:0] H_LAST_C = XW'(H_TOTAL - 1);
   localparam logic [YW-1:0] V_ACT_C  = YW'(V_ACTIVE);
   localparam logic [YW-1:0] V_SS_C   = YW'(V_ACTIVE + V_FP);
   localparam logic [YW-1:0] V_SE_C   = YW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [YW-1:0] V_LAST_C = YW'(V_TOTAL - 1);
   localparam logic          HS_ON    = (HSYNC_POL != 0);
   localparam logic          VS_ON    = (VSYNC_POL != 0);

   logic [XW-1:0]      h_q, h_d;
   logic [YW-1:0]      v_q, v_d;
   logic [FRAME_W-1:0] frame_q, frame_d;
   logic               hsync_q, hsync_d;
   logic               vsync_q, vsync_d;
   logic               de_q, de_d;
   logic [XW-1:0]      x_q, x_d;
   logic [YW-1:0]      y_q, y_d;
   logic               ls_q, ls_d;
   logic               fs_q, fs_d;
   logic               h_act, v_act;

   assign h_act = (h_q < H_ACT_C);
   assign v_act = (v_q < V_ACT_C);

   // Outputs capture the decode of the current position; counters then advance.
   always_comb begin
      h_d     = h_q;
      v_d     = v_q;
      frame_d = frame_q;
      hsync_d = hsync_q;
      vsync_d = vsync_q;
      de_d    = de_q;
      x_d     = x_q;
      y_d     = y_q;
      ls_d    = 1'b0;
      fs_d    = 1'b0;
      if (en) begin
         de_d    = h_act && v_act;
         x_d     = h_act ? h_q : '0;
         y_d     = v_act ? v_q : '0;
         hsync_d = ((h_q >= H_SS_C) && (h_q < H_SE_C)) ? HS_ON : ~HS_ON;
         vsync_d = ((v_q >= V_SS_C) && (v_q < V_SE_C)) ? VS_ON : ~VS_ON;
         ls_d    = (h_q == '0);
         fs_d    = (h_q == '0) && (v_q == '0);
         if (h_q == H_LAST_C) begin
            h_d = '0;
            if (v_q == V_LAST_C) begin
               v_d     = '0;
               frame_d = frame_q + FRAME_W'(1);
            end else begin
               v_d = v_q + YW'(1);
            end
         end else begin
            h_d = h_q + XW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         h_q     <= '0;
         v_q     <= '0;
         frame_q <= '0;
         hsync_q <= ~HS_ON;
         vsync_q <= ~VS_ON;
         de_q    <= 1'b0;
         x_q     <= '0;
         y_q     <= '0;
         ls_q    <= 1'b0;
         fs_q    <= 1'b0;
      end else begin
         h_q     <= h_d;
         v_q     <= v_d;
         frame_q <= frame_d;
         hsync_q <= hsync_d;
         vsync_q <= vsync_d;
         de_q    <= de_d;
         x_q     <= x_d;
         y_q     <= y_d;
         ls_q    <= ls_d;
         fs_q    <= fs_d;
      end
   end

`ifdef DEMOKIT_VGA_PIPE_EN
   // Unconditional retiming stage; en does not gate it, so pulses stay one clk wide.
   logic               hsync_p_q, vsync_p_q, de_p_q, ls_p_q, fs_p_q;
   logic [XW-1:0]      x_p_q;
   logic [YW-1:0]      y_p_q;
   logic [FRAME_W-1:0] frame_p_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         hsync_p_q <= ~HS_ON;
         vsync_p_q <= ~VS_ON;
         de_p_q    <= 1'b0;
         x_p_q     <= '0;
         y_p_q     <= '0;
         ls_p_q    <= 1'b0;
         fs_p_q    <= 1'b0;
         frame_p_q <= '0;
      end else begin
         hsync_p_q <= hsync_q;
         vsync_p_q <= vsync_q;
         de_p_q    <= de_q;
         x_p_q     <= x_q;
         y_p_q     <= y_q;
         ls_p_q    <= ls_q;
         fs_p_q    <= fs_q;
         frame_p_q <= frame_q;
      end
   end

   assign hsync       = hsync_p_q;
   assign vsync       = vsync_p_q;
   assign de          = de_p_q;
   assign x           = x_p_q;
   assign y           = y_p_q;
   assign line_start  = ls_p_q;
   assign frame_start = fs_p_q;
   assign frame       = frame_p_q;
`else
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign de          = de_q;
   assign x           = x_q;
   assign y           = y_q;
   assign line_start  = ls_q;
   assign frame_start = fs_q;
   assign frame       = frame_q;
`endif

endmodule

// File: tb/tb_demokit_vga_timing.sv
// tb/tb_demokit_vga_timing.sv - directed self-checking bench for demokit_vga_timing (small 8x6 raster, FRAME_W=2)
module tb_demokit_vga_timing;

`ifdef DEMOKIT_VGA_PIPE_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   typedef struct packed {
      logic       hs;
      logic       vs;
      logic       de;
      logic [2:0] x;
      logic [2:0] y;
      logic       ls;
      logic       fs;
      logic [1:0] fr;
   } smp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en  = 1'b0;
   logic       hsync, vsync, de, line_start, frame_start;
   logic [2:0] x, y;
   logic [1:0] frame;

   int   tests  = 0;
   int   fails  = 0;
   int   n      = 0;
   smp_t s [0:255];

   demokit_vga_timing #(
      .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .HSYNC_POL(0), .VSYNC_POL(0), .FRAME_W(2)
   ) dut (
      .clk(clk), .rst(rst), .en(en),
      .hsync(hsync), .vsync(vsync), .de(de), .x(x), .y(y),
      .line_start(line_start), .frame_start(frame_start), .frame(frame)
   );

   always #5 clk = ~clk;

   task automatic tick(input logic en_v, input logic rst_v);
      en  = en_v;
      rst = rst_v;
      @(posedge clk);
      #1;
      s[n].hs = hsync;
      s[n].vs = vsync;
      s[n].de = de;
      s[n].x  = x;
      s[n].y  = y;
      s[n].ls = line_start;
      s[n].fs = frame_start;
      s[n].fr = frame;
      n++;
   endtask

   // Index 0 is a reset edge, so response k belongs to enabled edge number k.
   task automatic start();
      n = 0;
      tick(1'b0, 1'b1);
   endtask

   task automatic flush();
      for (int i = 0; i < LAT - 1; i++) tick(1'b0, 1'b0);
   endtask

   function automatic smp_t resp(input int k);
      return s[k + LAT - 1];
   endfunction

   function automatic smp_t mk(input logic hs, input logic vs, input logic de_v,
                               input logic [2:0] xv, input logic [2:0] yv,
                               input logic ls, input logic fs, input logic [1:0] fr);
      smp_t r;
      r.hs = hs; r.vs = vs; r.de = de_v; r.x = xv; r.y = yv; r.ls = ls; r.fs = fs; r.fr = fr;
      return r;
   endfunction

   task automatic test_reset();
      smp_t got;
      n = 0;
      tick(1'b1, 1'b1);
      flush();
      got = resp(0);
      tests++;
      if (got !== mk(1, 1, 0, 0, 0, 0, 0, 0)) begin
         fails++;
         $display("FAIL reset got %h required %h", got, mk(1, 1, 0, 0, 0, 0, 0, 0));
      end
   endtask

   task automatic test_line();
      smp_t exp_t [1:9];
      smp_t got;
      exp_t[1] = mk(1, 1, 1, 0, 0, 1, 1, 0);
      exp_t[2] = mk(1, 1, 1, 1, 0, 0, 0, 0);
      exp_t[3] = mk(1, 1, 1, 2, 0, 0, 0, 0);
      exp_t[4] = mk(1, 1, 1, 3, 0, 0, 0, 0);
      exp_t[5] = mk(1, 1, 0, 0, 0, 0, 0, 0);
      exp_t[6] = mk(0, 1, 0, 0, 0, 0, 0, 0);
      exp_t[7] = mk(0, 1, 0, 0, 0, 0, 0, 0);
      exp_t[8] = mk(1, 1, 0, 0, 0, 0, 0, 0);
      exp_t[9] = mk(1, 1, 1, 0, 1, 1, 0, 0);
      start();
      for (int k = 1; k <= 9; k++) tick(1'b1, 1'b0);
      flush();
      for (int k = 1; k <= 9; k++) begin
         got = resp(k);
         tests++;
         if (got !== exp_t[k]) begin
            fails++;
            $display("FAIL line edge %0d got %h required %h", k, got, exp_t[k]);
         end
      end
   endtask

   task automatic test_frame();
      smp_t got;
      int   vs_low, fs_high;
      start();
      for (int k = 1; k <= 49; k++) tick(1'b1, 1'b0);
      flush();
      vs_low  = 0;
      fs_high = 0;
      for (int k = 1; k <= 49; k++) begin
         got = resp(k);
         if (got.vs == 1'b0) vs_low++;
         if (got.fs == 1'b1) fs_high++;
         tests++;
         if (got.vs !== ((k >= 33 && k <= 40) ? 1'b0 : 1'b1)) begin
            fails++;
            $display("FAIL frame_vsync edge %0d got %b", k, got.vs);
         end
      end
      tests++;
      if (vs_low != 8) begin
         fails++;
         $display("FAIL vsync_width got %0d required 8", vs_low);
      end
      tests++;
      if (fs_high != 2 || resp(49).fs !== 1'b1) begin
         fails++;
         $display("FAIL frame_start count %0d edge49 %b required 2 and 1", fs_high, resp(49).fs);
      end
      tests++;
      if (resp(47).fr !== 2'd0 || resp(48).fr !== 2'd1) begin
         fails++;
         $display("FAIL frame_inc got %0d,%0d required 0,1", resp(47).fr, resp(48).fr);
      end
      got = resp(17);
      tests++;
      if (got !== mk(1, 1, 1, 0, 2, 1, 0, 0)) begin
         fails++;
         $display("FAIL row2_start got %h required %h", got, mk(1, 1, 1, 0, 2, 1, 0, 0));
      end
      got = resp(25);
      tests++;
      if (got !== mk(1, 1, 0, 0, 0, 1, 0, 0)) begin
         fails++;
         $display("FAIL row3_blank got %h required %h", got, mk(1, 1, 0, 0, 0, 1, 0, 0));
      end
   endtask

   task automatic test_frame_wrap();
      logic [1:0] fr_e [1:4];
      fr_e[1] = 2'd1; fr_e[2] = 2'd2; fr_e[3] = 2'd3; fr_e[4] = 2'd0;
      start();
      for (int k = 1; k <= 192; k++) tick(1'b1, 1'b0);
      flush();
      for (int f = 1; f <= 4; f++) begin
         tests++;
         if (resp(48 * f).fr !== fr_e[f]) begin
            fails++;
            $display("FAIL frame_wrap frame %0d got %0d required %0d", f, resp(48 * f).fr, fr_e[f]);
         end
      end
   endtask

   task automatic test_en_toggle();
      logic [5:0] en_seq;
      smp_t exp_t [1:6];
      smp_t got;
      en_seq   = 6'b011001;
      exp_t[1] = mk(1, 1, 1, 0, 0, 1, 1, 0);
      exp_t[2] = mk(1, 1, 1, 0, 0, 0, 0, 0);
      exp_t[3] = mk(1, 1, 1, 0, 0, 0, 0, 0);
      exp_t[4] = mk(1, 1, 1, 1, 0, 0, 0, 0);
      exp_t[5] = mk(1, 1, 1, 2, 0, 0, 0, 0);
      exp_t[6] = mk(1, 1, 1, 2, 0, 0, 0, 0);
      start();
      for (int k = 1; k <= 6; k++) tick(en_seq[k-1], 1'b0);
      flush();
      for (int k = 1; k <= 6; k++) begin
         got = resp(k);
         tests++;
         if (got !== exp_t[k]) begin
            fails++;
            $display("FAIL en_toggle edge %0d got %h required %h", k, got, exp_t[k]);
         end
      end
   endtask

   task automatic test_mid_reset();
      smp_t got;
      start();
      for (int k = 1; k <= 21; k++) tick(1'b1, 1'b0);
      tick(1'b1, 1'b1);
      tick(1'b1, 1'b0);
      flush();
      got = resp(21);
      tests++;
      if (got !== mk(1, 1, 0, 0, 2, 0, 0, 0)) begin
         fails++;
         $display("FAIL pre_reset got %h required %h", got, mk(1, 1, 0, 0, 2, 0, 0, 0));
      end
      got = resp(22);
      tests++;
      if (got !== mk(1, 1, 0, 0, 0, 0, 0, 0)) begin
         fails++;
         $display("FAIL mid_reset got %h required %h", got, mk(1, 1, 0, 0, 0, 0, 0, 0));
      end
      got = resp(23);
      tests++;
      if (got !== mk(1, 1, 1, 0, 0, 1, 1, 0)) begin
         fails++;
         $display("FAIL after_reset got %h required %h", got, mk(1, 1, 1, 0, 0, 1, 1, 0));
      end
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      test_line();
      test_frame();
      test_frame_wrap();
      test_en_toggle();
      test_mid_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
